fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Downstream consumer of the synchronous FIFO: pops one WIDTH-bit word at a time and transmits it as an asynchronous serial (UART-style) frame.
- Frame format: start bit, data LSB first, optional even parity, 1 or 2 stop bits.
- Sits between the FIFO read port and the chip-level serial pin, in the FIFO's clock domain.

Parameters:
- WIDTH, 8, data word width; must match the FIFO WIDTH.
- CLK_DIV, 16, clk cycles per serial bit; minimum 2.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = permitted to start new frames.
- fifo_data  in  WIDTH  FIFO read data; valid the cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  single-cycle pop strobe to the FIFO.
- tx  out  1  serial line; idle high.
- busy  out  1  high from FETCH through the end of the last stop bit.
- frame_cnt  out  16  count of completed frames; wraps.

Behaviour:
- Reset values (asynchronous): tx=1, fifo_rd_en=0, busy=0, frame_cnt=0, state=IDLE, bit counter=0, divider=0, shift register=0.
- FSM states: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1. If enable=1 and fifo_empty=0, go to FETCH.
- FETCH: lasts exactly 1 cycle.
  - fifo_rd_en=1 for exactly this cycle; busy=1; tx=1.
  - fifo_rd_en is never asserted when fifo_empty=1.
- LOAD: lasts 1 cycle; fifo_data is captured into the shift register and parity is computed (XOR of all bits); tx=1.
- START: tx=0 for CLK_DIV cycles.
- DATA: WIDTH bits, each held CLK_DIV cycles, LSB first; shift right on each bit boundary.
- PARITY: entered only if PARITY_EN=1; tx = XOR of data (even parity); held CLK_DIV cycles.
- STOP: tx=1 for STOP_BITS*CLK_DIV cycles.
- On the last STOP cycle:
  - frame_cnt increments; 16'hFFFF wraps to 0.
  - If enable=1 and fifo_empty=0, go to FETCH; otherwise go to IDLE.
- Divider: counts 0..CLK_DIV-1 and resets at each bit boundary. Bit counter width is $clog2(WIDTH+1).
- Frame length: (1+WIDTH+PARITY_EN+STOP_BITS)*CLK_DIV cycles.
- Back-to-back frames: exactly 2 idle-high cycles (FETCH, LOAD) between the end of one stop period and the next start bit.
- Latency: first start bit begins 2 cycles after the IDLE→FETCH decision cycle, i.e. start edge at cycle N+3 if fifo_empty falls at cycle N with enable=1.
- enable deasserted mid-frame: current frame completes; no new FETCH.
- enable deasserted during FETCH/LOAD: the popped word is still transmitted; no data loss.
- fifo_empty rising mid-frame: no effect until the STOP decision.
- Reset mid-frame: tx returns high immediately; the in-flight word is discarded; frame_cnt clears.
- tx is registered: no combinational path from any input to tx.

Test Plan:
- Reset, CLK_DIV=4, PARITY_EN=0, STOP_BITS=1, FIFO preloaded with 8'hA5, enable=1 → fifo_rd_en one pulse; tx sequence 0,1,0,1,0,0,1,0,1,1 (each bit 4 clks); frame 40 clks; frame_cnt=1; busy falls after stop.
- FIFO holds 8'h01, 8'h80, 8'hFF with enable held → three frames; exactly 2 high cycles between frames; three fifo_rd_en pulses; frame_cnt=3; no pop while fifo_empty=1.
- PARITY_EN=1, STOP_BITS=2, data 8'h07 → parity bit=1; 2 stop bits = 8 clks; frame 48 clks; data 8'h03 → parity bit=0.
- enable dropped during DATA of first of two queued words → first frame completes; no second FETCH until enable returns; then second frame follows with the same 2-cycle setup.
- reset pulsed mid-DATA → tx=1 in the same cycle (async); state IDLE; frame_cnt=0; next frame starts only after reset release with the FIFO non-empty.
- frame_cnt preset by 65535 frames (or forced) → next completed frame gives frame_cnt=0.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read port, enable and serial-side outputs of the FIFO-to-UART transmitter.
interface fifo_uart_tx_if #(parameter int WIDTH = 8);
    logic enable;
    logic [WIDTH-1:0] fifo_data;
    logic fifo_empty;
    logic fifo_rd_en;
    logic tx;
    logic busy;
    logic [15:0] frame_cnt;
    modport master(output enable, fifo_data, fifo_empty, input fifo_rd_en, tx, busy, frame_cnt);
    modport slave(input enable, fifo_data, fifo_empty, output fifo_rd_en, tx, busy, frame_cnt);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops FIFO words and sends each as a UART frame
// (start, data LSB first, optional even parity, 1 or 2 stop bits).
module fifo_uart_tx #(
    parameter int WIDTH = 8,
    parameter int CLK_DIV = 16,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input logic clk,
    input logic reset,
    fifo_uart_tx_if.slave bus
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(WIDTH + 1);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
    state_t state, state_n;
    logic [DW-1:0] div, div_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic par, par_n, tx_n, tick, more;
    logic [15:0] cnt_n;
    assign tick = div == DW'(CLK_DIV - 1);
    assign more = bus.enable && !bus.fifo_empty;
    always_comb begin
        state_n = state;
        div_n = (state inside {START, DATA, PARITY, STOP}) && !tick ? div + DW'(1) : '0;
        bit_n = bit_cnt;
        sr_n = sr;
        par_n = par;
        cnt_n = bus.frame_cnt;
        case (state)
            IDLE: state_n = more ? FETCH : IDLE;
            FETCH: state_n = LOAD;
            LOAD: begin
                state_n = START;
                sr_n = bus.fifo_data;
                par_n = ^bus.fifo_data;
            end
            START: state_n = tick ? DATA : START;
            DATA: if (tick) begin
                if (bit_cnt == BW'(WIDTH - 1)) begin
                    state_n = PARITY_EN != 0 ? PARITY : STOP;
                    bit_n = '0;
                end else begin
                    bit_n = bit_cnt + BW'(1);
                    sr_n = sr >> 1;
                end
            end
            PARITY: state_n = tick ? STOP : PARITY;
            STOP: if (tick) begin
                if (bit_cnt == BW'(STOP_BITS - 1)) begin
                    bit_n = '0;
                    cnt_n = bus.frame_cnt + 16'd1;
                    state_n = more ? FETCH : IDLE;
                end else begin
                    bit_n = bit_cnt + BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        // tx is driven from next-state values so the registered line lines up with state
        tx_n = state_n == START ? 1'b0 :
               state_n == DATA ? sr_n[0] :
               state_n == PARITY ? par_n : 1'b1;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            div <= '0;
            bit_cnt <= '0;
            sr <= '0;
            par <= 1'b0;
            bus.tx <= 1'b1;
            bus.fifo_rd_en <= 1'b0;
            bus.busy <= 1'b0;
            bus.frame_cnt <= '0;
        end else begin
            state <= state_n;
            div <= div_n;
            bit_cnt <= bit_n;
            sr <= sr_n;
            par <= par_n;
            bus.tx <= tx_n;
            bus.fifo_rd_en <= state_n == FETCH;
            bus.busy <= state_n != IDLE;
            bus.frame_cnt <= cnt_n;
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two transmitters (8N1 and 8E2, CLK_DIV=4) fed identical word streams,
// checked each cycle against a frame-position model and by a sampling receiver against literal frames.
module tb_fifo_uart_tx;
    localparam int CD = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    always #5 clk = ~clk;

    fifo_uart_tx_if #(.WIDTH(8)) b0();
    fifo_uart_tx_if #(.WIDTH(8)) b1();
    fifo_uart_tx #(.WIDTH(8), .CLK_DIV(CD), .PARITY_EN(0), .STOP_BITS(1)) dut0(.clk(clk), .reset(reset), .bus(b0));
    fifo_uart_tx #(.WIDTH(8), .CLK_DIV(CD), .PARITY_EN(1), .STOP_BITS(2)) dut1(.clk(clk), .reset(reset), .bus(b1));
    assign b0.enable = en;
    assign b1.enable = en;

    logic [1:0] tx_w, rd_w, busy_w, emp_w;
    logic [15:0] cnt_w [2];
    assign tx_w = {b1.tx, b0.tx};
    assign rd_w = {b1.fifo_rd_en, b0.fifo_rd_en};
    assign busy_w = {b1.busy, b0.busy};
    assign emp_w = {b1.fifo_empty, b0.fifo_empty};
    assign cnt_w[0] = b0.frame_cnt;
    assign cnt_w[1] = b1.frame_cnt;

    // FIFO models: data appears the cycle after the pop strobe
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    always @(posedge clk) if (b0.fifo_rd_en && q0.size() != 0) b0.fifo_data <= q0.pop_front();
    always @(posedge clk) if (b1.fifo_rd_en && q1.size() != 0) b1.fifo_data <= q1.pop_front();
    always @(negedge clk) begin
        b0.fifo_empty <= q0.size() == 0;
        b1.fifo_empty <= q1.size() == 0;
    end

    function automatic int nb(int i);
        return i == 0 ? 10 : 12;
    endfunction
    function automatic logic [7:0] head(int i);
        return i == 0 ? q0[0] : q1[0];
    endfunction
    function automatic int qsize(int i);
        return i == 0 ? q0.size() : q1.size();
    endfunction

    // Model: pos = cycles into the transaction (1=pop, 2=load, 3.. = frame), 0 = idle
    int pos [2] = '{0, 0};
    logic [7:0] word [2];
    logic [15:0] mcnt [2] = '{16'd0, 16'd0};
    logic preset = 1'b0;
    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                pos[i] <= 0;
                mcnt[i] <= 16'd0;
            end else if (pos[i] == 0 || pos[i] == 2 + nb(i) * CD) begin
                pos[i] <= (en && !emp_w[i]) ? 1 : 0;
                if (en && !emp_w[i]) word[i] <= head(i);
                if (pos[i] != 0) mcnt[i] <= mcnt[i] + 16'd1;
                else if (preset) mcnt[i] <= 16'hFFFF;
            end else begin
                pos[i] <= pos[i] + 1;
            end
        end
    end

    logic [7:0] lit_data [10] = '{8'hA5, 8'h01, 8'h80, 8'hFF, 8'h07, 8'h03, 8'h3C, 8'hC3, 8'hAA, 8'h0F};
    logic lit_par [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    function automatic logic [11:0] expv(int i, int f);
        return i == 0 ? {3'b001, lit_data[f], 1'b0} : {2'b11, lit_par[f], lit_data[f], 1'b0};
    endfunction

    int total = 0;
    int bad = 0;
    logic lit_req = 1'b0;
    logic [15:0] lit_cnt = 16'd0;
    int lit_fi = 0;
    task automatic chk(string nm, int i, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    logic rx_on [2] = '{1'b0, 1'b0};
    int rx_c [2];
    logic [11:0] rx_b [2];
    int fi [2] = '{0, 0};
    int p, k;
    logic etx;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            p = pos[i];
            k = (p - 3) / CD;
            etx = p < 3 ? 1'b1 : k == 0 ? 1'b0 : k <= 8 ? word[i][k-1] : (i == 1 && k == 9) ? ^word[i] : 1'b1;
            chk("tx", i, int'(tx_w[i]), int'(etx));
            chk("rd_en", i, int'(rd_w[i]), int'(p == 1));
            chk("busy", i, int'(busy_w[i]), int'(p != 0));
            chk("frame_cnt", i, int'(cnt_w[i]), int'(mcnt[i]));
            if (rd_w[i]) chk("pop_nonempty", i, int'(qsize(i) != 0), 1);
            if (reset) rx_on[i] = 1'b0;
            else if (!rx_on[i] && !tx_w[i]) begin
                rx_on[i] = 1'b1;
                rx_c[i] = 0;
                rx_b[i] = '0;
            end
            if (rx_on[i]) begin
                if (rx_c[i] % CD == 1) rx_b[i][rx_c[i] / CD] = tx_w[i];
                if (rx_c[i] == nb(i) * CD - 1) begin
                    rx_on[i] = 1'b0;
                    if (fi[i] < 10) chk("frame_bits", i, int'(rx_b[i]), int'(expv(i, fi[i])));
                    else chk("frame_extra", i, fi[i], 9);
                    fi[i]++;
                end
                rx_c[i]++;
            end
            if (lit_req) begin
                chk("lit_frame_cnt", i, int'(cnt_w[i]), int'(lit_cnt));
                chk("lit_frames_rx", i, fi[i], lit_fi);
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic push(logic [7:0] v);
        q0.push_back(v);
        q1.push_back(v);
    endtask
    task automatic lit(logic [15:0] c, int f);
        lit_cnt = c;
        lit_fi = f;
        lit_req = 1'b1;
        cyc(1);
        lit_req = 1'b0;
    endtask

    initial begin
        en = 1'b1;
        push(8'hA5);
        cyc(3);
        reset = 1'b0;
        cyc(60);
        lit(16'd1, 1);
        push(8'h01); push(8'h80); push(8'hFF);
        cyc(170);
        lit(16'd4, 4);
        push(8'h07); push(8'h03);
        cyc(120);
        lit(16'd6, 6);
        push(8'h3C); push(8'hC3);
        cyc(12);
        en = 1'b0;
        cyc(100);
        en = 1'b1;
        cyc(70);
        lit(16'd8, 8);
        push(8'h00);
        cyc(20);
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(5);
        lit(16'd0, 8);
        push(8'hAA);
        cyc(70);
        lit(16'd1, 9);
        preset = 1'b1;
        cyc(1);
        preset = 1'b0;
        force b0.frame_cnt = 16'hFFFF;
        force b1.frame_cnt = 16'hFFFF;
        cyc(2);
        release b0.frame_cnt;
        release b1.frame_cnt;
        cyc(2);
        lit(16'hFFFF, 9);
        push(8'h0F);
        cyc(70);
        lit(16'd0, 10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
